data_mem_responder: RTL and testbench

- Data-memory target serving the pipeline's MEM-stage load/store port.
- Accepts one request at a time over a valid/ready handshake and applies a programmable wait-state latency.
- Performs RV32I byte, halfword and word accesses with sign or zero extension.
- Returns the result over a separate valid/ready response channel; flags misaligned, out-of-range and illegal-width accesses.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_lane_align.sv | 71 +++++++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, store replication,
// load extraction with sign/zero extension, and width/alignment fault detection.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign rhalf = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o    = '0;
    wlane_o = '0;
    rdata_o = '0;
    fault_o = 1'b0;
    if (we_i) begin
      unique case (funct3_i)
        F3_B: begin
          be_o    = 4'b0001 << addr_lo_i;
          wlane_o = {4{wdata_i[7:0]}};
        end
        F3_H: begin
          fault_o = addr_lo_i[0];
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wlane_o = {2{wdata_i[15:0]}};
        end
        F3_W: begin
          fault_o = (addr_lo_i != 2'b00);
          be_o    = '1;
          wlane_o = wdata_i;
        end
        default: fault_o = 1'b1;
      endcase
    end else begin
      unique case (funct3_i)
        F3_B:  rdata_o = {{24{rbyte[7]}}, rbyte};
        F3_BU: rdata_o = {24'd0, rbyte};
        F3_H: begin
          fault_o = addr_lo_i[0];
          rdata_o = {{16{rhalf[15]}}, rhalf};
        end
        F3_HU: begin
          fault_o = addr_lo_i[0];
          rdata_o = {16'd0, rhalf};
        end
        F3_W: begin
          fault_o = (addr_lo_i != 2'b00);
          rdata_o = rword_i;
        end
        default: fault_o = 1'b1;
      endcase
    end
    if (fault_o) begin
      be_o    = '0;
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory target: one request at a time, programmable wait states,
// RV32I sub-word accesses and a held response channel with fault reporting.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        access;

  logic [31:0] mem_q [DEPTH_WORDS];

  // With zero wait states the access happens on the accept edge, so the
  // aligner must see the live request rather than the latched copy.
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [2:0]  acc_f3;
  logic [31:0] acc_wdata;
  logic [AW-1:0] acc_idx;
  logic        acc_oor;
  logic        acc_err;
  logic [31:0] rword;
  logic [3:0]  al_be;
  logic [31:0] al_wlane;
  logic [31:0] al_rdata;
  logic        al_fault;

  assign acc_we    = (state_q == IDLE) ? req_we     : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign acc_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_oor   = (acc_addr[31:2] >= 30'(DEPTH_WORDS));
  assign acc_err   = acc_oor | al_fault;
  assign rword     = mem_q[acc_idx];

  mem_lane_align u_align (
    .we_i      (acc_we),
    .addr_lo_i (acc_addr[1:0]),
    .funct3_i  (acc_f3),
    .wdata_i   (acc_wdata),
    .rword_i   (rword),
    .be_o      (al_be),
    .wlane_o   (al_wlane),
    .rdata_o   (al_rdata),
    .fault_o   (al_fault)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q <= (acc_err || acc_we) ? '0 : al_rdata;
        err_q   <= acc_err;
      end
    end
  end

  // Storage is not reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && access && acc_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (al_be[b]) mem_q[acc_idx][8*b +: 8] <= al_wlane[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model predicts
// each response; per-instance monitors check data, fault flag, latency and hold.
module tb_data_mem_responder;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr   [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_wdata  [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata  [2];
  logic [1:0]  rsp_err;

  bit [1:0]    rr_force;
  bit [1:0]    rr_val;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mdl [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name, string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Reference: legality from the width code, then plain byte arithmetic.
  function automatic void ref_access(int s, bit we, logic [31:0] addr, logic [2:0] f3,
                                     logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned size;
    int unsigned base;
    bit legal;
    logic [31:0] v;
    rd  = '0;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = !legal || (addr % size != 0) || (addr / 4 >= 64);
    if (err) return;
    base = addr;
    if (we) begin
      for (int unsigned i = 0; i < size; i++) mdl[s][base+i] = 8'((wd >> (8*i)) & 32'hFF);
    end else begin
      v = '0;
      for (int unsigned i = 0; i < size; i++) v = v | (32'(mdl[s][base+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8*size));
      rd = v;
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned W = (g == 0) ? 1 : 3;
    exp_t        q[$];
    int unsigned acc_cyc = 0;
    bit          seen = 0;
    logic [31:0] hold = '0;
    exp_t        e;

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W)) dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_funct3 (req_funct3[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );

    always @(negedge clk) begin
      if (rst[g]) begin
        seen = 0;
      end else begin
        if (req_valid[g] && req_ready[g]) acc_cyc = cyc;
        if (rsp_valid[g]) begin
          chk("req_ready_low_in_resp", 32'(req_ready[g]), 32'd0);
          if (!seen) begin
            seen = 1;
            hold = rsp_rdata[g];
            chk("latency_cycles", cyc - acc_cyc, W + 1);
          end else begin
            chk("rsp_rdata_stable", rsp_rdata[g], hold);
          end
          if (rsp_ready[g]) begin
            if (q.size() == 0) begin
              fail("unexpected_rsp", "response with no request outstanding");
            end else begin
              e = q.pop_front();
              chk("rsp_rdata", rsp_rdata[g], e.rdata);
              chk("rsp_err", 32'(rsp_err[g]), 32'(e.err));
            end
            seen = 0;
          end
        end
      end
    end
  end

  function automatic int qsize(int s);
    return (s == 0) ? u[0].q.size() : u[1].q.size();
  endfunction

  task automatic issue(int s, bit we, logic [31:0] addr, logic [2:0] f3, logic [31:0] wd, bit track);
    exp_t e;
    int n = 0;
    if (track) begin
      ref_access(s, we, addr, f3, wd, e.rdata, e.err);
      if (s == 0) u[0].q.push_back(e);
      else        u[1].q.push_back(e);
    end
    @(posedge clk); #1;
    req_we[s]     = we;
    req_addr[s]   = addr;
    req_funct3[s] = f3;
    req_wdata[s]  = wd;
    req_valid[s]  = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready[s]) break;
      n++;
      if (n > 200) begin
        fail("accept_timeout", "req_ready never rose");
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[s]  = 1'b0;
    // Scramble the request bus: the responder must rely on its latched copy.
    req_we[s]     = 1'($urandom);
    req_addr[s]   = $urandom;
    req_funct3[s] = 3'($urandom);
    req_wdata[s]  = $urandom;
  endtask

  task automatic drain(int s);
    int n = 0;
    while (qsize(s) != 0 || !req_ready[s]) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        fail("drain_timeout", "responses still outstanding");
        break;
      end
    end
  endtask

  initial begin
    rsp_ready = 2'b11;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        rsp_ready[i] = rr_force[i] ? rr_val[i] : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0] f3_tab [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;

    rst       = 2'b11;
    req_valid = '0;
    req_we    = '0;
    rr_force  = '0;
    rr_val    = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_funct3[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("reset_rsp_err", 32'(rsp_err[0]), 32'd0);
    rst = 2'b00;

    for (int unsigned w = 0; w < 64; w++) issue(0, 1'b1, 32'(w * 4), F3_W, $urandom, 1'b1);

    issue(0, 1'b1, 32'h10, F3_W, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b0, 32'h10, F3_W, '0, 1'b1);
    issue(0, 1'b0, 32'h13, F3_B, '0, 1'b1);
    issue(0, 1'b0, 32'h13, F3_BU, '0, 1'b1);
    issue(0, 1'b0, 32'h12, F3_H, '0, 1'b1);
    issue(0, 1'b0, 32'h10, F3_HU, '0, 1'b1);
    issue(0, 1'b1, 32'h11, F3_B, 32'h00000055, 1'b1);
    issue(0, 1'b0, 32'h10, F3_W, '0, 1'b1);
    issue(0, 1'b1, 32'h21, F3_H, 32'h0000AAAA, 1'b1);
    issue(0, 1'b0, 32'h22, F3_W, '0, 1'b1);
    issue(0, 1'b0, 32'h100, F3_W, '0, 1'b1);
    issue(0, 1'b1, 32'h100, F3_W, 32'h11111111, 1'b1);
    issue(0, 1'b0, 32'h20, F3_W, '0, 1'b1);
    issue(0, 1'b0, 32'h10, 3'b110, '0, 1'b1);
    issue(0, 1'b1, 32'h10, 3'b011, 32'hFFFFFFFF, 1'b1);
    issue(0, 1'b0, 32'h10, F3_W, '0, 1'b1);
    drain(0);

    // Backpressure: response must hold while rsp_ready stays low.
    rr_force[0]  = 1'b1;
    rr_val[0]    = 1'b0;
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, F3_W, '0, 1'b1);
    for (int n = 0; n < 20 && !rsp_valid[0]; n++) @(negedge clk);
    chk("bp_rsp_valid_seen", 32'(rsp_valid[0]), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid_held", 32'(rsp_valid[0]), 32'd1);
      chk("bp_req_ready_low", 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk); #2;
    rr_val[0]    = 1'b1;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_req_ready", 32'(req_ready[0]), 32'd1);
    chk("bp_release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    rr_force[0] = 1'b0;
    drain(0);

    repeat (300) begin
      we   = 1'($urandom);
      f3   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : f3_tab[$urandom_range(0, 4)];
      addr = 32'($urandom_range(0, 32'h10F));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      end
      issue(0, we, addr, f3, $urandom, 1'b1);
    end
    drain(0);

    // Reset during WAIT on the three-wait-state instance.
    issue(1, 1'b1, 32'h30, F3_W, 32'hCAFEF00D, 1'b1);
    issue(1, 1'b0, 32'h30, F3_W, '0, 1'b1);
    drain(1);
    issue(1, 1'b1, 32'h30, F3_W, 32'h12345678, 1'b0);
    @(posedge clk); #2;
    rst[1] = 1'b1;
    #1;
    chk("wait_rst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("wait_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("wait_rst_rsp_rdata", rsp_rdata[1], 32'd0);
    chk("wait_rst_rsp_err", 32'(rsp_err[1]), 32'd0);
    @(posedge clk); #2;
    rst[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(rsp_valid[1]), 32'd0);
    end
    issue(1, 1'b0, 32'h30, F3_W, '0, 1'b1);
    drain(1);

    chk("leftover_q0", 32'(u[0].q.size()), 32'd0);
    chk("leftover_q1", 32'(u[1].q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
